// File: rtl/sum_pipe_pkg.sv
// Shared defaults and the stage record for the sum_pipe registered adder.
package sum_pipe_pkg;

  localparam int SUM_PIPE_WIDTH_DEF  = 8;
  localparam int SUM_PIPE_STAGES_DEF = 2;

  // Default-width view of one stage; modules re-declare it at their own WIDTH.
  typedef struct packed {
    logic                          vld;
    logic                          carry;
    logic [SUM_PIPE_WIDTH_DEF-1:0] sum;
  } sum_stage_t;

endpackage

// File: rtl/sum_pipe_stage.sv
// One elastic register slot of sum_pipe: holds {vld, carry, sum} and advances
// whenever it is empty or the downstream slot advances.
module sum_pipe_stage
  import sum_pipe_pkg::*;
#(
  parameter int WIDTH = SUM_PIPE_WIDTH_DEF
) (
  input  logic             clk,
  input  logic             aresetn,
  input  logic             up_vld_i,
  input  logic             up_carry_i,
  input  logic [WIDTH-1:0] up_sum_i,
  input  logic             adv_next_i,
  output logic             adv_o,
  output logic             vld_o,
  output logic             carry_o,
  output logic [WIDTH-1:0] sum_o
);

  typedef struct packed {
    logic             vld;
    logic             carry;
    logic [WIDTH-1:0] sum;
  } stage_t;

  stage_t stage_q, stage_d;

  // Data only loads on an accepted beat so idle bubbles never overwrite it.
  always_comb begin
    adv_o   = !stage_q.vld || adv_next_i;
    stage_d = stage_q;
    if (adv_o) begin
      stage_d.vld = up_vld_i;
      if (up_vld_i) begin
        stage_d.sum   = up_sum_i;
        stage_d.carry = up_carry_i;
      end
    end
  end

  always_ff @(posedge clk or negedge aresetn) begin
    if (!aresetn) begin
      stage_q <= '0;
    end else begin
      stage_q <= stage_d;
    end
  end

  assign vld_o   = stage_q.vld;
  assign carry_o = stage_q.carry;
  assign sum_o   = stage_q.sum;

endmodule

// File: rtl/sum_pipe.sv
// Back-pressurable pipelined adder c = a + b with carry-out over STAGES slots.
// Define SUM_PIPE_SAT_EN to saturate c to all ones when the sum overflows.
module sum_pipe
  import sum_pipe_pkg::*;
#(
  parameter int WIDTH  = SUM_PIPE_WIDTH_DEF,
  parameter int STAGES = SUM_PIPE_STAGES_DEF
) (
  input  logic             clk,
  input  logic             aresetn,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             in_valid,
  output logic             in_ready,
  output logic [WIDTH-1:0] c,
  output logic             c_carry,
  output logic             out_valid,
  input  logic             out_ready
);

  // Chain index 0 is the entry adder; index k+1 is the output of slot k.
  logic [STAGES:0] adv;
  logic [STAGES:0] vldChain;
  logic [STAGES:0] carryChain;
  logic [WIDTH-1:0] sumChain [STAGES+1];
  logic [WIDTH:0]   entrySum;

  assign entrySum      = {1'b0, a} + {1'b0, b};
  assign sumChain[0]   = entrySum[WIDTH-1:0];
  assign carryChain[0] = entrySum[WIDTH];
  assign vldChain[0]   = in_valid;
  assign adv[STAGES]   = out_ready;

  for (genvar k = 0; k < STAGES; k++) begin : gStage
    sum_pipe_stage #(
      .WIDTH(WIDTH)
    ) uStage (
      .clk        (clk),
      .aresetn    (aresetn),
      .up_vld_i   (vldChain[k]),
      .up_carry_i (carryChain[k]),
      .up_sum_i   (sumChain[k]),
      .adv_next_i (adv[k+1]),
      .adv_o      (adv[k]),
      .vld_o      (vldChain[k+1]),
      .carry_o    (carryChain[k+1]),
      .sum_o      (sumChain[k+1])
    );
  end

  assign in_ready  = adv[0];
  assign out_valid = vldChain[STAGES];
  assign c_carry   = carryChain[STAGES];

  always_comb begin
    c = sumChain[STAGES];
`ifdef SUM_PIPE_SAT_EN
    if (carryChain[STAGES]) begin
      c = '1;
    end
`endif
  end

endmodule

// File: tb/tb_sum_pipe.sv
// Scoreboard bench for sum_pipe: an 8-bit/2-stage instance and a 16-bit/1-stage
// instance; expected sums are queued on input handshakes and popped on output ones.
module tb_sum_pipe;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        aresetn;
  logic [7:0]  a8, b8, c8;
  logic        inValid8, inReady8, outValid8, outReady8, carry8;
  logic [15:0] a16, b16, c16;
  logic        inValid16, inReady16, outValid16, outReady16, carry16;

  int totalCount = 0;
  int badCount   = 0;
  int pushCount8 = 0, popCount8 = 0, pushCount16 = 0, popCount16 = 0;

  logic [8:0]  sb8  [$];
  logic [16:0] sb16 [$];
  logic [8:0]  exp8;
  logic [16:0] exp16;

  sum_pipe #(.WIDTH(8), .STAGES(2)) dut8 (
    .clk(clk), .aresetn(aresetn), .a(a8), .b(b8), .in_valid(inValid8),
    .in_ready(inReady8), .c(c8), .c_carry(carry8), .out_valid(outValid8),
    .out_ready(outReady8)
  );

  sum_pipe #(.WIDTH(16), .STAGES(1)) dut16 (
    .clk(clk), .aresetn(aresetn), .a(a16), .b(b16), .in_valid(inValid16),
    .in_ready(inReady16), .c(c16), .c_carry(carry16), .out_valid(outValid16),
    .out_ready(outReady16)
  );

  // Reference results are stored as {carry, c} exactly as the consumer should see them.
  function automatic logic [8:0] model8(input logic [7:0] x, input logic [7:0] y);
    logic [8:0] s;
    s = {1'b0, x} + {1'b0, y};
`ifdef SUM_PIPE_SAT_EN
    if (s[8]) s[7:0] = 8'hFF;
`endif
    return s;
  endfunction

  function automatic logic [16:0] model16(input logic [15:0] x, input logic [15:0] y);
    logic [16:0] s;
    s = {1'b0, x} + {1'b0, y};
`ifdef SUM_PIPE_SAT_EN
    if (s[16]) s[15:0] = 16'hFFFF;
`endif
    return s;
  endfunction

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    totalCount++;
    if (observed !== expected) begin
      badCount++;
      $display("[TB] FAIL %s: got %0h, wanted %0h at %0t", tag, observed, expected, $time);
    end
  endtask

  // Called at a negedge with inputs driven; resolves the handshakes of the coming posedge.
  task automatic clockCycle();
    #1;
    if (outValid8 && outReady8) begin
      popCount8++;
      if (sb8.size() == 0) checkOutput("sb8_extra", outValid8, 0);
      else begin
        exp8 = sb8.pop_front();
        checkOutput("c8", c8, exp8[7:0]);
        checkOutput("carry8", carry8, exp8[8]);
      end
    end
    if (inValid8 && inReady8) begin
      sb8.push_back(model8(a8, b8));
      pushCount8++;
    end
    if (outValid16 && outReady16) begin
      popCount16++;
      if (sb16.size() == 0) checkOutput("sb16_extra", outValid16, 0);
      else begin
        exp16 = sb16.pop_front();
        checkOutput("c16", c16, exp16[15:0]);
        checkOutput("carry16", carry16, exp16[16]);
      end
    end
    if (inValid16 && inReady16) begin
      sb16.push_back(model16(a16, b16));
      pushCount16++;
    end
    @(negedge clk);
  endtask

  task automatic applyStimulus(input logic v, input logic [7:0] av, input logic [7:0] bv, input logic rdy);
    inValid8  = v;
    a8        = av;
    b8        = bv;
    outReady8 = rdy;
    clockCycle();
  endtask

  task automatic drainAll(input int budget);
    inValid8   = 1'b0;
    inValid16  = 1'b0;
    outReady8  = 1'b1;
    outReady16 = 1'b1;
    for (int n = 0; n < budget && (sb8.size() != 0 || sb16.size() != 0); n++) clockCycle();
    checkOutput("drain8_left", sb8.size(), 0);
    checkOutput("drain16_left", sb16.size(), 0);
  endtask

  initial begin
    aresetn = 1'b0;
    {a8, b8, a16, b16} = '0;
    inValid8 = 1'b0; inValid16 = 1'b0;
    outReady8 = 1'b1; outReady16 = 1'b1;
    repeat (2) @(negedge clk);
    checkOutput("rst_valid", outValid8, 0);
    checkOutput("rst_c", c8, 0);
    checkOutput("rst_carry", carry8, 0);
    aresetn = 1'b1;
    #1;
    checkOutput("rst_inready", inReady8, 1);
    @(negedge clk);

    // Single beat latency
    applyStimulus(1'b1, 8'd2, 8'd3, 1'b1);
    checkOutput("lat_early_valid", outValid8, 0);
    applyStimulus(1'b0, 8'd0, 8'd0, 1'b1);
    checkOutput("lat_valid", outValid8, 1);
    checkOutput("lat_c", c8, 5);
    checkOutput("lat_carry", carry8, 0);
    drainAll(10);

    // Wrap-around / saturation
    applyStimulus(1'b1, 8'd200, 8'd100, 1'b1);
    drainAll(10);

    // Back-to-back stream
    for (int i = 0; i < 10; i++) begin
      if (i >= 2) checkOutput("stream_valid", outValid8, 1);
      checkOutput("stream_inready", inReady8, 1);
      applyStimulus(1'b1, 8'(i), 8'(i), 1'b1);
    end
    drainAll(10);

    // Fill under stall, then simultaneous pop and push
    applyStimulus(1'b1, 8'd1, 8'd1, 1'b0);
    applyStimulus(1'b1, 8'd2, 8'd2, 1'b0);
    checkOutput("full_inready", inReady8, 0);
    checkOutput("full_valid", outValid8, 1);
    checkOutput("full_c", c8, 2);
    applyStimulus(1'b1, 8'd3, 8'd3, 1'b0);
    checkOutput("stall_c", c8, 2);
    checkOutput("stall_valid", outValid8, 1);
    checkOutput("stall_inready", inReady8, 0);
    outReady8 = 1'b1;
    #1;
    checkOutput("poppush_inready", inReady8, 1);
    applyStimulus(1'b1, 8'd3, 8'd3, 1'b1);
    checkOutput("poppush_c", c8, 4);
    drainAll(10);
    checkOutput("poppush_count", popCount8, pushCount8);

    // Reset with results in flight
    applyStimulus(1'b1, 8'd5, 8'd5, 1'b0);
    applyStimulus(1'b1, 8'd6, 8'd6, 1'b0);
    inValid8 = 1'b0;
    #2 aresetn = 1'b0;
    #1;
    checkOutput("midrst_valid", outValid8, 0);
    sb8.delete();
    sb16.delete();
    @(negedge clk);
    aresetn = 1'b1;
    #1;
    checkOutput("midrst_inready", inReady8, 1);
    @(negedge clk);
    for (int i = 0; i < 4; i++) begin
      applyStimulus(1'b0, 8'd0, 8'd0, 1'b1);
      checkOutput("midrst_stale", outValid8, 0);
    end

    // 16-bit single-stage overflow
    a16 = 16'hFFFF; b16 = 16'h0001; inValid16 = 1'b1; outReady16 = 1'b1;
    exp16 = model16(16'hFFFF, 16'h0001);
    clockCycle();
    inValid16 = 1'b0;
    checkOutput("w16_valid", outValid16, 1);
    checkOutput("w16_c", c16, exp16[15:0]);
    checkOutput("w16_carry", carry16, 1);
    drainAll(10);

    // Random valid/ready on both instances
    pushCount8 = 0; popCount8 = 0; pushCount16 = 0; popCount16 = 0;
    for (int n = 0; n < 1000; n++) begin
      inValid8   = 1'($urandom_range(0, 1));
      outReady8  = 1'($urandom_range(0, 1));
      a8         = 8'($urandom);
      b8         = 8'($urandom);
      inValid16  = 1'($urandom_range(0, 1));
      outReady16 = 1'($urandom_range(0, 1));
      a16        = 16'($urandom);
      b16        = 16'($urandom);
      clockCycle();
    end
    drainAll(20);
    checkOutput("rand_count8", popCount8, pushCount8);
    checkOutput("rand_count16", popCount16, pushCount16);

    $display("test done: total=%0d bad=%0d", totalCount, badCount);
    $finish;
  end

endmodule
